word_serializer: RTL

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/word_serializer.sv | 93 +++++++++
 1 files changed

// File: rtl/word_serializer.sv
// Breaks a 32-bit word into 1..4 bytes on a valid/ready byte stream.
// Loading a new word in the same cycle the last byte leaves gives gap-free streaming.
module word_serializer #(
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic [2:0]  in_len,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy,
  output logic [15:0] word_count
);

  // Handshake: a transfer happens on a rising edge when valid && ready on that
  // side; valid never waits for ready, and data/last hold while valid && !ready.
  typedef enum logic {IDLE, SEND} state_t;

  state_t      state;
  logic [31:0] word_q;
  logic [2:0]  len_q;
  logic [1:0]  idx_q;
  logic [15:0] count_q;

  logic        in_xfer;
  logic        out_xfer;
  logic [2:0]  eff_len;
  logic [1:0]  byte_sel;
  logic [7:0]  cur_byte;

  // Lengths outside 1..4 mean a full word.
  assign eff_len = (in_len == 3'd0 || in_len > 3'd4) ? 3'd4 : in_len;

  assign busy      = (state == SEND);
  assign out_valid = busy;
  assign out_last  = busy && ({1'b0, idx_q} == (len_q - 3'd1));
  assign in_ready  = !busy || (out_ready && out_last);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    byte_sel = LSB_FIRST ? idx_q : (2'd3 - idx_q);
    cur_byte = word_q[{byte_sel, 3'b000} +: 8];
  end

  assign out_data   = busy ? cur_byte : 8'h00;
  assign word_count = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      word_q  <= 32'h0;
      len_q   <= 3'd0;
      idx_q   <= 2'd0;
      count_q <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (in_xfer) begin
            word_q <= in_data;
            len_q  <= eff_len;
            idx_q  <= 2'd0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (out_xfer) begin
            if (out_last) begin
              count_q <= count_q + 16'd1;
              // A coinciding input transfer reloads without leaving SEND.
              if (in_xfer) begin
                word_q <= in_data;
                len_q  <= eff_len;
                idx_q  <= 2'd0;
              end else begin
                state <= IDLE;
              end
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
